// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multiplier wait/timeout, branch flush.
// Latency: every output is registered, so a condition sampled at an edge appears in the following cycle.
// Backpressure: asserts stall_load_o / valid_stall_o to hold upstream stages; it never waits on anything except mul_done_i.
module pipeline_hazard_ctrl #(
  parameter int MUL_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instr_i,
  input  logic [5:0]  ex_main_opcode_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        branch_taken_i,
  input  logic        mul_done_i,
  output logic        stall_load_o,
  output logic        valid_stall_o,
  output logic        flush_o,
  output logic        mul_start_o,
  output logic        mul_busy_o,
  output logic        mul_timeout_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_BUBBLE   = 2'b01,
    S_MUL_WAIT = 2'b10,
    S_FLUSH    = 2'b11
  } state_t;

  // Last counter value of a multiplier wait; MUL_TIMEOUT <= 2**CNT_W so this never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             guard_q, guard_d;
  logic             timeout_d;
  logic             load_hit, mul_hit, rs2_user;
  logic             stall_d, wait_d, flush_d, start_d;

  // Fields of instr_i that take no part in hazard detection.
  logic unused_bits;
  assign unused_bits = ^{instr_i[31:25], instr_i[14:7], instr_i[1:0], ex_main_opcode_i[1:0]};

  // Branch, store and register-register ALU formats read rs2; everything else only rs1.
  assign rs2_user = (instr_i[6:2] == 5'b11000) || (instr_i[6:2] == 5'b01100) ||
                    (instr_i[6:2] == 5'b01000);
  assign load_hit = (ex_main_opcode_i[5:3] == 3'b100) && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == instr_i[19:15]) || (rs2_user && (ex_rd_i == instr_i[24:20])));
  // The guard blocks relaunch while the just-finished mul opcode is still in the decode register.
  assign mul_hit  = (ex_main_opcode_i[5:2] == 4'b1111) && !guard_q;

  // Next-state, counter, guard and sticky-flag logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    guard_d   = guard_q;
    timeout_d = mul_timeout_o;
    case (state_q)
      S_IDLE: begin
        guard_d = 1'b0;
        if (branch_taken_i) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else if (mul_hit) begin
          state_d = S_MUL_WAIT;
          cnt_d   = '0;
        end else if (load_hit) begin
          state_d = S_BUBBLE;
        end
      end
      S_BUBBLE: begin
        state_d = S_IDLE;
      end
      S_MUL_WAIT: begin
        if (mul_done_i) begin
          state_d = S_IDLE;
          guard_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          guard_d   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the cycle after the edge, derived from the next state.
  always_comb begin
    stall_d = (state_d == S_BUBBLE);
    wait_d  = (state_d == S_MUL_WAIT);
    flush_d = (state_d == S_FLUSH);
    start_d = (state_d == S_MUL_WAIT) && (state_q != S_MUL_WAIT);
  end

  // State, counter, guard and all outputs; synchronous reset aborts any activity.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      guard_q       <= 1'b0;
      stall_load_o  <= 1'b0;
      valid_stall_o <= 1'b0;
      flush_o       <= 1'b0;
      mul_start_o   <= 1'b0;
      mul_busy_o    <= 1'b0;
      mul_timeout_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      guard_q       <= guard_d;
      stall_load_o  <= stall_d;
      valid_stall_o <= wait_d;
      flush_o       <= flush_d;
      mul_start_o   <= start_d;
      mul_busy_o    <= wait_d;
      mul_timeout_o <= timeout_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-value queue.
// Each step drives inputs, queues the expected output vector, then checks one cycle later.
// Output vector layout: {state[1:0], stall_load, valid_stall, flush, mul_start, mul_busy, mul_timeout}.
module tb_pipeline_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] instr_i = '0;
  logic [5:0]  ex_main_opcode_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        branch_taken_i = 1'b0;
  logic        mul_done_i = 1'b0;
  logic        stall_load_o, valid_stall_o, flush_o, mul_start_o, mul_busy_o, mul_timeout_o;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  localparam logic [5:0]  OP_NOP = 6'b000000;
  localparam logic [5:0]  OP_LD  = 6'b100010;
  localparam logic [5:0]  OP_MUL = 6'b111100;
  localparam logic [31:0] I_ADD  = 32'h00728333; // add x6,x5,x7 (rs1=5)
  localparam logic [31:0] I_ADDI = 32'h00508313; // addi x6,x1,5 (rs2 field=5, not read)
  localparam logic [31:0] I_SW   = 32'h0050A023; // sw x5,0(x1) (rs2=5)
  localparam logic [31:0] I_ADD0 = 32'h00000333; // add x6,x0,x0

  localparam logic [7:0] E_IDLE    = 8'b00_000000;
  localparam logic [7:0] E_IDLE_TO = 8'b00_000001;
  localparam logic [7:0] E_BUB     = 8'b01_100000;
  localparam logic [7:0] E_MW_ST   = 8'b10_010110;
  localparam logic [7:0] E_MW      = 8'b10_010010;
  localparam logic [7:0] E_FL      = 8'b11_001000;

  pipeline_hazard_ctrl #(.MUL_TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .instr_i          (instr_i),
    .ex_main_opcode_i (ex_main_opcode_i),
    .ex_rd_i          (ex_rd_i),
    .branch_taken_i   (branch_taken_i),
    .mul_done_i       (mul_done_i),
    .stall_load_o     (stall_load_o),
    .valid_stall_o    (valid_stall_o),
    .flush_o          (flush_o),
    .mul_start_o      (mul_start_o),
    .mul_busy_o       (mul_busy_o),
    .mul_timeout_o    (mul_timeout_o),
    .state_o          (state_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of inputs, queue the expectation, check it after the next rising edge.
  task automatic step(input logic [31:0] ins, input logic [5:0] op, input logic [4:0] rd,
                      input logic br, input logic dn, input logic rs,
                      input logic [7:0] ex, input string tag);
    logic [7:0] obs, exp_v;
    string      t;
    instr_i          = ins;
    ex_main_opcode_i = op;
    ex_rd_i          = rd;
    branch_taken_i   = br;
    mul_done_i       = dn;
    reset_i          = rs;
    exp_q.push_back(ex);
    tag_q.push_back(tag);
    @(posedge clk_i);
    #1;
    obs   = {state_o, stall_load_o, valid_stall_o, flush_o, mul_start_o, mul_busy_o, mul_timeout_o};
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", t, obs, exp_v);
    end
  endtask

  initial begin
    #1;
    // Reset state
    step(0, OP_NOP, 0, 0, 0, 1, E_IDLE, "reset");
    step(0, OP_NOP, 0, 0, 0, 0, E_IDLE, "idle_after_reset");

    // Load-use on rs1, bubble ignores held inputs and a branch
    step(I_ADD, OP_LD, 5, 0, 0, 0, E_BUB, "load_rs1_bubble");
    step(I_ADD, OP_LD, 5, 1, 0, 0, E_IDLE, "bubble_one_cycle");
    step(0, OP_NOP, 0, 0, 0, 0, E_IDLE, "idle_nop");

    // No hazard: rs2 field of an I-type, and rd=x0
    step(I_ADDI, OP_LD, 5, 0, 0, 0, E_IDLE, "addi_no_stall");
    step(I_ADD0, OP_LD, 0, 0, 0, 0, E_IDLE, "rd0_no_stall");

    // Store reads rs2
    step(I_SW, OP_LD, 5, 0, 0, 0, E_BUB, "store_rs2_bubble");
    step(0, OP_NOP, 0, 0, 0, 0, E_IDLE, "store_bubble_end");

    // Branch beats load hit; flush lasts two cycles ignoring inputs
    step(I_ADD, OP_LD, 5, 1, 0, 0, E_FL, "flush_c1");
    step(I_ADD, OP_LD, 5, 1, 0, 0, E_FL, "flush_c2");
    step(I_ADD, OP_LD, 5, 1, 0, 0, E_IDLE, "flush_end");
    step(0, OP_NOP, 0, 0, 0, 0, E_IDLE, "flush_idle");

    // Branch beats mul hit
    step(0, OP_MUL, 0, 1, 0, 0, E_FL, "br_over_mul_c1");
    step(0, OP_NOP, 0, 0, 0, 0, E_FL, "br_over_mul_c2");
    step(0, OP_NOP, 0, 0, 0, 0, E_IDLE, "br_over_mul_end");

    // Mul done in the 4th wait cycle; branch and load ignored while waiting
    step(0, OP_MUL, 0, 0, 0, 0, E_MW_ST, "mul_c1_start");
    step(0, OP_MUL, 0, 0, 0, 0, E_MW, "mul_c2");
    step(I_ADD, OP_MUL, 5, 1, 0, 0, E_MW, "mul_c3_ignore_br");
    step(0, OP_MUL, 0, 0, 0, 0, E_MW, "mul_c4");
    step(0, OP_MUL, 0, 0, 1, 0, E_IDLE, "mul_done_exit");
    step(0, OP_MUL, 0, 0, 0, 0, E_IDLE, "mul_guard_block");

    // Relaunch after guard clears, then run to timeout
    step(0, OP_MUL, 0, 0, 0, 0, E_MW_ST, "to_c1_start");
    for (int i = 2; i <= 16; i++) begin
      step(0, OP_MUL, 0, 0, 0, 0, E_MW, $sformatf("to_c%0d", i));
    end
    step(0, OP_MUL, 0, 0, 0, 0, E_IDLE_TO, "timeout_exit");
    step(0, OP_MUL, 0, 0, 0, 0, E_IDLE_TO, "timeout_guard");
    step(I_ADD, OP_LD, 5, 0, 0, 0, 8'b01_100001, "timeout_sticky_bubble");
    step(0, OP_NOP, 0, 0, 0, 0, E_IDLE_TO, "timeout_sticky");
    step(0, OP_NOP, 0, 0, 0, 1, E_IDLE, "reset_clears_timeout");

    // Done coinciding with the timeout cycle: done wins
    step(0, OP_MUL, 0, 0, 0, 0, E_MW_ST, "co_c1_start");
    for (int i = 2; i <= 16; i++) begin
      step(0, OP_MUL, 0, 0, 0, 0, E_MW, $sformatf("co_c%0d", i));
    end
    step(0, OP_NOP, 0, 0, 1, 0, E_IDLE, "co_done_wins");
    step(0, OP_NOP, 0, 0, 0, 0, E_IDLE, "co_no_timeout");

    // Reset in the 3rd wait cycle aborts and clears the guard
    step(0, OP_MUL, 0, 0, 0, 0, E_MW_ST, "rst_c1_start");
    step(0, OP_MUL, 0, 0, 0, 0, E_MW, "rst_c2");
    step(0, OP_MUL, 0, 0, 0, 0, E_MW, "rst_c3");
    step(0, OP_MUL, 0, 0, 0, 1, E_IDLE, "rst_mid_mul");
    step(0, OP_MUL, 0, 0, 0, 0, E_MW_ST, "rst_no_guard_relaunch");

    // Reset in the middle of a flush
    step(0, OP_NOP, 0, 0, 0, 1, E_IDLE, "rst_before_flush");
    step(0, OP_NOP, 0, 1, 0, 0, E_FL, "flush2_c1");
    step(0, OP_NOP, 0, 0, 0, 1, E_IDLE, "rst_mid_flush");
    step(0, OP_NOP, 0, 0, 0, 0, E_IDLE, "idle_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
